// File: rtl/snake_pixel_render.sv
// Tile-based pixel renderer for a snake game: a 2-bit cell grid is looked up
// per pixel through a 3-stage pipeline, with sync signals delayed to match.
module snake_pixel_render #(
  parameter int GRID_W = 40,
  parameter int GRID_H = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        active_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        wr_en,
  input  logic [10:0] wr_addr,
  input  logic [1:0]  wr_data,
  output logic [3:0]  R,
  output logic [3:0]  G,
  output logic [3:0]  B,
  output logic        HS,
  output logic        VS,
  output logic        busy,
  output logic        frame_tick,
  output logic [0:0]  o_dbg_state
);

  localparam int              N_CELLS  = GRID_W * GRID_H;
  localparam int              AW       = $clog2(N_CELLS);
  localparam logic [15:0]     N16      = 16'(N_CELLS);
  localparam logic [AW-1:0]   CLR_LAST = AW'(N_CELLS - 1);
  localparam logic [9:0]      COL_LAST = 10'(GRID_W - 1);
  localparam logic [9:0]      ROW_LAST = 10'(GRID_H - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [1:0]    r_mem [0:N_CELLS-1];
  logic [0:0]    r_state;
  logic [AW-1:0] r_clr_addr;

  logic          w_we;
  logic [AW-1:0] w_wa;
  logic [1:0]    w_wd;

  logic [9:0]    w_col;
  logic [9:0]    w_row;
  logic [15:0]   w_s1_addr;
  logic          w_s1_border;

  logic [AW-1:0] r_addr;
  logic          r_addr_ok;
  logic          r_act1, r_bord1, r_hs1, r_vs1;
  logic [1:0]    r_cell;
  logic          r_act2, r_bord2, r_hs2, r_vs2;
  logic [11:0]   w_rgb;
  logic          r_vs_prev;

  assign busy        = (r_state == ST_CLEAR);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == ST_CLEAR) begin
      if (r_clr_addr == CLR_LAST) begin
        r_state    <= ST_RUN;
        r_clr_addr <= '0;
      end else begin
        r_clr_addr <= r_clr_addr + 1'b1;
      end
    end
  end

  // The clear sweep owns the write port; game writes are dropped until RUN.
  always_comb begin
    w_we = 1'b0;
    w_wa = '0;
    w_wd = 2'd0;
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        w_we = 1'b1;
        w_wa = r_clr_addr;
      end else if (wr_en && ({5'd0, wr_addr} < N16)) begin
        w_we = 1'b1;
        w_wa = wr_addr[AW-1:0];
        w_wd = wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  always_comb begin
    w_col       = pix_x >> 4;
    w_row       = pix_y >> 4;
    w_s1_addr   = 16'(w_row) * 16'(GRID_W) + 16'(w_col);
    w_s1_border = (w_row == 10'd0) || (w_row == ROW_LAST) ||
                  (w_col == 10'd0) || (w_col == COL_LAST);
  end

  always_comb begin
    w_rgb = 12'h000;
    if (r_act2) begin
      if (r_bord2) begin
        w_rgb = 12'h888;
      end else begin
        case (r_cell)
          2'd1:    w_rgb = 12'h0F0;
          2'd2:    w_rgb = 12'hFF0;
          2'd3:    w_rgb = 12'hF00;
          default: w_rgb = 12'h000;
        endcase
      end
    end
  end

  // Sync levels reset high (inactive) so the monitor sees no spurious pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_addr_ok  <= 1'b0;
      r_act1     <= 1'b0;
      r_bord1    <= 1'b0;
      r_hs1      <= 1'b1;
      r_vs1      <= 1'b1;
      r_cell     <= 2'd0;
      r_act2     <= 1'b0;
      r_bord2    <= 1'b0;
      r_hs2      <= 1'b1;
      r_vs2      <= 1'b1;
      R          <= 4'h0;
      G          <= 4'h0;
      B          <= 4'h0;
      HS         <= 1'b1;
      VS         <= 1'b1;
      r_vs_prev  <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      r_addr     <= w_s1_addr[AW-1:0];
      r_addr_ok  <= (w_s1_addr < N16);
      r_act1     <= active_in;
      r_bord1    <= w_s1_border;
      r_hs1      <= hs_in;
      r_vs1      <= vs_in;
      r_cell     <= r_addr_ok ? r_mem[r_addr] : 2'd0;
      r_act2     <= r_act1;
      r_bord2    <= r_bord1;
      r_hs2      <= r_hs1;
      r_vs2      <= r_vs1;
      R          <= w_rgb[11:8];
      G          <= w_rgb[7:4];
      B          <= w_rgb[3:0];
      HS         <= r_hs2;
      VS         <= r_vs2;
      r_vs_prev  <= vs_in;
      frame_tick <= r_vs_prev & ~vs_in;
    end
  end

endmodule

// File: tb/tb_snake_pixel_render.sv
// Randomized bench for snake_pixel_render: a cell-array reference model
// predicts every pixel and sync level three cycles ahead.
module tb_snake_pixel_render;

  localparam int W = 40;
  localparam int H = 30;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pix_x, pix_y;
  logic        active_in, hs_in, vs_in;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [1:0]  wr_data;
  logic [3:0]  R, G, B;
  logic        HS, VS, busy, frame_tick;
  logic [0:0]  o_dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int model_mem [N];
  logic [13:0] exp_q [$];
  int          tag_q [$];
  int          food_cells [20];

  snake_pixel_render #(.GRID_W(W), .GRID_H(H)) dut (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y),
    .active_in(active_in), .hs_in(hs_in), .vs_in(vs_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .R(R), .G(G), .B(B), .HS(HS), .VS(VS),
    .busy(busy), .frame_tick(frame_tick), .o_dbg_state(o_dbg_state)
  );

  always #20 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] ref_pixel(input int x, input int y,
                                            input bit act, input bit hs, input bit vs);
    logic [11:0] rgb;
    int col, row;
    col = x / 16;
    row = y / 16;
    rgb = 12'h000;
    if (act) begin
      if (row == 0 || row == H - 1 || col == 0 || col == W - 1) rgb = 12'h888;
      else begin
        case (model_mem[row * W + col])
          1:       rgb = 12'h0F0;
          2:       rgb = 12'hFF0;
          3:       rgb = 12'hF00;
          default: rgb = 12'h000;
        endcase
      end
    end
    return {rgb, hs, vs};
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < N; i++) model_mem[i] = 0;
  endfunction

  // One cycle of pixel stimulus with an optional cell write; the output
  // three applications back is compared against its queued prediction.
  task automatic pix_cycle(input int x, input int y, input bit act, input bit hs,
                           input bit vs, input bit we, input int wa, input int wd);
    logic [13:0] got, e_val;
    int tag;
    @(negedge clk);
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    active_in = act;
    hs_in     = hs;
    vs_in     = vs;
    wr_en     = we;
    wr_addr   = 11'(wa);
    wr_data   = 2'(wd);
    if (we && wa < N) model_mem[wa] = wd;
    exp_q.push_back(ref_pixel(x, y, act, hs, vs));
    tag_q.push_back(y * 1024 + x);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (exp_q.size() == 3) begin
      e_val = exp_q.pop_front();
      tag   = tag_q.pop_front();
      got   = {R, G, B, HS, VS};
      n_checks++;
      if (got !== e_val) begin
        n_errors++;
        $display("FAIL pixel x=%0d y=%0d got rgbhv=%h expected %h", tag % 1024, tag / 1024, got, e_val);
      end
    end
  endtask

  task automatic pix_flush();
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    exp_q.delete();
    tag_q.delete();
  endtask

  task automatic scan_all_cells();
    for (int i = 0; i < N; i++) begin
      pix_cycle((i % W) * 16 + int'($urandom_range(0, 15)), (i / W) * 16 + int'($urandom_range(0, 15)),
                1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    end
    pix_flush();
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_x = '0; pix_y = '0; active_in = 1'b1;
    hs_in = 1'b0; vs_in = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if ({R, G, B} !== 12'h000) begin n_errors++; $display("FAIL reset_rgb got %h expected 000", {R, G, B}); end
    n_checks++;
    if (HS !== 1'b1 || VS !== 1'b1) begin n_errors++; $display("FAIL reset_sync got HS=%b VS=%b expected 1 1", HS, VS); end
    n_checks++;
    if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick got %b expected 0", frame_tick); end
    n_checks++;
    if (busy !== 1'b1 || o_dbg_state !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy got busy=%b state=%b expected 1 0", busy, o_dbg_state);
    end
  endtask

  task automatic test_clear();
    int cnt;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    hs_in = 1'b1;
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1000) begin
        wr_en = 1'b1; wr_addr = 11'd100; wr_data = 2'd3;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
    n_checks++;
    if (cnt != N) begin n_errors++; $display("FAIL clear_length got %0d cycles expected %0d", cnt, N); end
    n_checks++;
    if (o_dbg_state !== 1'b1) begin n_errors++; $display("FAIL clear_state got %b expected 1", o_dbg_state); end
    scan_all_cells();
  endtask

  task automatic test_write_latency();
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 41, 2);
    pix_cycle(16, 16, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    pix_cycle(15, 16, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if ({R, G, B} !== 12'hFF0) begin n_errors++; $display("FAIL latency_head got %h expected FF0", {R, G, B}); end
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if ({R, G, B} !== 12'h888) begin n_errors++; $display("FAIL latency_border got %h expected 888", {R, G, B}); end
    pix_flush();
  endtask

  task automatic test_read_during_write();
    pix_cycle(32, 16, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    pix_cycle(33, 17, 1'b1, 1'b1, 1'b1, 1'b1, 42, 1);
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if ({R, G, B} !== 12'h000) begin n_errors++; $display("FAIL rdw_old got %h expected 000", {R, G, B}); end
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    n_checks++;
    if ({R, G, B} !== 12'h0F0) begin n_errors++; $display("FAIL rdw_new got %h expected 0F0", {R, G, B}); end
    pix_flush();
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      pix_cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'(i % 2),
                int'($urandom_range(0, 1299)), int'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 300; i++) begin
      pix_cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end
    pix_flush();
  endtask

  task automatic test_blank_sync();
    int c;
    for (int i = 0; i < 20; i++) begin
      food_cells[i] = int'($urandom_range(1, H - 2)) * W + int'($urandom_range(1, W - 2));
      pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, food_cells[i], 3);
    end
    for (int i = 0; i < 200; i++) begin
      c = food_cells[$urandom_range(0, 19)];
      pix_cycle((c % W) * 16 + int'($urandom_range(0, 15)), (c / W) * 16 + int'($urandom_range(0, 15)),
                1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end
    for (int i = 0; i < 20; i++) begin
      c = food_cells[i];
      pix_cycle((c % W) * 16 + 8, (c / W) * 16 + 8, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    end
    pix_flush();
  endtask

  task automatic test_oor_write();
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1200, 3);
    pix_cycle(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 2047, 3);
    pix_flush();
    scan_all_cells();
  endtask

  task automatic test_frame_tick();
    int pulses;
    @(negedge clk);
    vs_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL tick_idle got %b expected 0", frame_tick); end
    @(negedge clk);
    vs_in = 1'b0;
    pulses = 0;
    for (int i = 0; i < 1600; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        n_checks++;
        if (frame_tick !== 1'b1) begin n_errors++; $display("FAIL tick_first got %b expected 1", frame_tick); end
      end
      if (frame_tick === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin n_errors++; $display("FAIL tick_count got %0d pulses expected 1", pulses); end
    @(negedge clk);
    vs_in = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL tick_rise got %b expected 0", frame_tick); end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL midclr_enter got busy=%b expected 1", busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (600) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL midclr_600 got busy=%b expected 1", busy); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b1) begin n_errors++; $display("FAIL midclr_hold got busy=%b expected 1", busy); end
    end
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 2000) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    n_checks++;
    if (cnt != N) begin n_errors++; $display("FAIL midclr_length got %0d cycles expected %0d", cnt, N); end
    model_clear();
    scan_all_cells();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_write_latency();
    test_read_during_write();
    test_random();
    test_blank_sync();
    test_oor_write();
    test_frame_tick();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_pixel_render.md
SNAKE_PIXEL_RENDER -- requirements
Module: snake_pixel_render

Interface
REQ-001 SHALL have parameter GRID_W, default 40, meaning grid columns (cell width fixed at 16 px).
REQ-002 SHALL have parameter GRID_H, default 30, meaning grid rows (cell height fixed at 16 px).
REQ-003 SHALL have port: clk  input  1  25 MHz pixel clock, the same clock that drives the VGA timing counters.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: pix_x  input  10  horizontal pixel coordinate, 0..639 in the active region.
REQ-006 SHALL have port: pix_y  input  10  vertical pixel coordinate, 0..479 in the active region.
REQ-007 SHALL have port: active_in  input  1  display-enable for the current pix_x/pix_y.
REQ-008 SHALL have port: hs_in, vs_in  input  1 each  sync levels from the timing generator.
REQ-009 SHALL have port: wr_en  input  1  cell write strobe from game logic.
REQ-010 SHALL have port: wr_addr  input  11  cell index, row*GRID_W + col.
REQ-011 SHALL have port: wr_data  input  2  cell code: 0 empty, 1 body, 2 head, 3 food.
REQ-012 SHALL have port: R, G, B  output  4 each  pixel colour.
REQ-013 SHALL have port: HS, VS  output  1 each  sync levels delayed to align with R/G/B.
REQ-014 SHALL have port: busy  output  1  high while the grid clear is in progress.
REQ-015 SHALL have port: frame_tick  output  1  single-cycle pulse marking the start of vertical sync.

Function
REQ-016 SHALL hold GRID_W*GRID_H 2-bit cells in internal memory with one synchronous read port and one synchronous write port.
REQ-017 SHALL run a three-stage pipeline:
- S1 registers addr = (pix_y>>4)*GRID_W + (pix_x>>4).
- S2 performs the registered memory read.
- S3 registers the colour mapping.
REQ-018 SHALL present R/G/B for a given pix_x/pix_y exactly 3 clk cycles after that coordinate is applied.
REQ-019 SHALL delay active_in, hs_in and vs_in through the same 3 stages so that HS/VS/R/G/B stay cycle-aligned.
REQ-020 SHALL map cell codes to colour as: 0 = 000, 1 = 0F0, 2 = FF0, 3 = F00 (hex R,G,B nibbles).
REQ-021 SHALL override the cell colour with 888 (grey border) when the cell lies in row 0, row GRID_H-1, column 0 or column GRID_W-1.
REQ-022 SHALL drive R/G/B to 000 whenever the delayed active flag is low, regardless of memory contents.
REQ-023 SHALL ignore S1 address results for out-of-range coordinates; when active_in is low, the memory read value is don't-care and the output is blanked.
REQ-024 SHALL, on a read and a write to the same address in the same cycle, return the old (pre-write) data.
REQ-025 SHALL ignore writes with wr_addr >= GRID_W*GRID_H; memory is unchanged.
REQ-026 SHALL assert frame_tick for exactly one cycle on the clk following a change of vs_in from 1 to 0 (active-low sync), with no other pulses.
REQ-027 SHALL implement clear FSM state CLEAR: write 0 to addresses 0..GRID_W*GRID_H-1, one per cycle, with busy=1 throughout.
REQ-028 SHALL implement clear FSM state RUN: after the last address is cleared, transition CLEAR->RUN, with busy=0.
REQ-029 SHALL ignore wr_en while in CLEAR, and SHALL continue the pixel pipeline during CLEAR.
REQ-030 SHALL honour wr_en in RUN the cycle it is asserted, with the written data visible to reads starting the following cycle.

Reset
REQ-031 SHALL, when rst is sampled high, clear all pipeline registers, drive R/G/B=000, HS=1, VS=1, frame_tick=0 and busy=1 on the next cycle, and enter CLEAR at address 0.
REQ-032 SHALL, on rst asserted mid-clear or mid-frame, restart the clear at address 0; no partial state is retained.
REQ-033 SHALL complete the clear GRID_W*GRID_H cycles (1200 by default) after rst deasserts, at which point busy falls.

Verification
REQ-034 SHALL verify the clear sequence: release rst -> busy high exactly 1200 cycles, then low; every cell reads 0 (black interior, 888 border).
REQ-035 SHALL verify write-to-pixel latency: after busy falls, write addr 41 data 2, then apply pix_x=16, pix_y=16, active_in=1 -> R/G/B = FF0 exactly 3 cycles later; pix_x=15 -> 888.
REQ-036 SHALL verify blanking and alignment: toggle hs_in/vs_in with active_in=0 over food cells -> R/G/B = 000; HS/VS equal their inputs delayed by 3 cycles.
REQ-037 SHALL verify frame_tick: drive vs_in 1->0 -> exactly one frame_tick pulse; holding vs_in low for 1600 cycles produces no further pulses.
REQ-038 SHALL verify write edge cases: write addr 1200 data 3 -> no cell changes; wr_en during CLEAR -> ignored, cell remains 0.
REQ-039 SHALL verify reset mid-clear: assert rst at clear address 600 -> busy stays high, clear restarts, and busy falls 1200 cycles after rst release.
